// File: rtl/risc_sequencer.sv
// ============================================================================
// risc_sequencer
// ----------------------------------------------------------------------------
// Instruction-cycle controller for the 8-bit RISC CPU. Every instruction runs
// through an eight-phase fetch/decode/execute loop; the control strobes for
// the address mux, memory, instruction register, accumulator, program counter
// and data-bus driver are decoded combinationally from the current phase, the
// opcode in IR[7:5] and the ALU zero flag.
//
// Opcode map: HLT 000, SKZ 001, ADD 010, AND 011, XOR 100, LDA 101,
//             STO 110, JMP 111.
//
// Parameters
//   IC_W      width of the retired-instruction counter
//   PHASES    phases per instruction (fixed at 8; sets the wrap phase)
//
// Ports
//   clk        in   system clock, rising-edge active
//   rst_n      in   asynchronous active-low reset
//   ena        in   run enable; low at an edge aborts to phase 0
//   opcode     in   IR[7:5], stable from phase 3 through phase 7
//   zero       in   ALU zero flag, consulted in phase 6 only
//   sel        out  address mux select: 1 = PC, 0 = IR operand
//   rd         out  memory read
//   wr         out  memory write
//   ld_ir      out  load instruction register
//   ld_ac      out  load accumulator from ALU result
//   ld_pc      out  load PC from IR operand
//   inc_pc     out  increment PC
//   data_e     out  drive accumulator onto the data bus
//   halt       out  CPU halted (also asserted in phase 4 of a HLT)
//   phase      out  current phase, for debug
//   instr_cnt  out  retired-instruction count, wraps
//   step       in   single-step advance (only with RISC_SEQ_SINGLE_STEP_EN)
//
// Optional feature macro: RISC_SEQ_SINGLE_STEP_EN
//   When defined, the sequencer parks in phase 0 until a rising edge samples
//   step=1 together with ena=1. Holding step high gives free run.
// ============================================================================
module risc_sequencer #(
    parameter int IC_W   = 16,
    parameter int PHASES = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [2:0]      opcode,
    input  logic            zero,
    output logic            sel,
    output logic            rd,
    output logic            wr,
    output logic            ld_ir,
    output logic            ld_ac,
    output logic            ld_pc,
    output logic            inc_pc,
    output logic            data_e,
    output logic            halt,
    output logic [2:0]      phase,
    output logic [IC_W-1:0] instr_cnt
`ifdef RISC_SEQ_SINGLE_STEP_EN
    ,
    input  logic            step
`endif
);

    // ------------------------------------------------------------------
    // Phase and opcode encodings
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    // Last phase of the loop; the edge leaving it retires the instruction.
    localparam phase_t PH_LAST = phase_t'(3'(PHASES - 1));

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    phase_t          phase_reg;
    logic            halted_reg;
    logic [IC_W-1:0] instr_cnt_reg;

    // Permission to leave phase 0. Without single-step this is always true.
    logic step_ok;

`ifdef RISC_SEQ_SINGLE_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Sequencer FSM
    // Priority: halted (frozen) > ena low (abort) > HLT in phase 4 >
    //           single-step park in phase 0 > normal advance.
    // An abort coincident with HLT in phase 4 therefore never sets halted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg     <= PH_INST_ADDR;
            halted_reg    <= 1'b0;
            instr_cnt_reg <= '0;
        end else if (halted_reg) begin
            // Only reset leaves the halted state; everything is frozen.
            phase_reg     <= PH_INST_ADDR;
        end else if (!ena) begin
            phase_reg     <= PH_INST_ADDR;
        end else if ((phase_reg == PH_OP_ADDR) && (opcode == OP_HLT)) begin
            halted_reg    <= 1'b1;
            phase_reg     <= PH_INST_ADDR;
        end else if ((phase_reg == PH_INST_ADDR) && !step_ok) begin
            phase_reg     <= PH_INST_ADDR;
        end else if (phase_reg == PH_LAST) begin
            phase_reg     <= PH_INST_ADDR;
            instr_cnt_reg <= instr_cnt_reg + 1'b1;
        end else begin
            phase_reg     <= phase_t'(phase_reg + 3'd1);
        end
    end

    // ------------------------------------------------------------------
    // Strobe decode
    // ------------------------------------------------------------------
    logic is_aluop;
    logic is_hlt;
    logic is_skz;
    logic is_sto;
    logic is_jmp;

    // Opcodes whose result comes back through the ALU into the accumulator.
    assign is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                      (opcode == OP_XOR) || (opcode == OP_LDA);
    assign is_hlt   = (opcode == OP_HLT);
    assign is_skz   = (opcode == OP_SKZ);
    assign is_sto   = (opcode == OP_STO);
    assign is_jmp   = (opcode == OP_JMP);

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        inc_pc = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;

        if (halted_reg) begin
            // Halted CPU: every strobe, including sel, is quiet.
            halt = 1'b1;
        end else begin
            case (phase_reg)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    // HLT announces itself here, one edge before halted sets.
                    inc_pc = !is_hlt;
                    halt   = is_hlt;
                end
                PH_OP_FETCH: begin
                    rd = is_aluop;
                end
                PH_ALU_OP: begin
                    rd     = is_aluop;
                    inc_pc = is_skz && zero;
                    ld_pc  = is_jmp;
                    data_e = is_sto;
                end
                PH_STORE: begin
                    rd     = is_aluop;
                    ld_ac  = is_aluop;
                    ld_pc  = is_jmp;
                    wr     = is_sto;
                    data_e = is_sto;
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

    assign phase     = phase_reg;
    assign instr_cnt = instr_cnt_reg;

endmodule

// File: tb/tb_risc_sequencer.sv
module tb_risc_sequencer;

    localparam int IC_W = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ena = 1'b0;
    logic [2:0]      opcode = 3'b010;
    logic            zero = 1'b0;
    logic            step = 1'b1;
    logic            sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
    logic [2:0]      phase;
    logic [IC_W-1:0] instr_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference state: instruction-level view of the sequencer.
    int  m_phase = 0;
    bit  m_halted = 0;
    int  m_cnt = 0;

    always #5 clk = ~clk;

    risc_sequencer #(.IC_W(IC_W), .PHASES(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .opcode    (opcode),
        .zero      (zero),
        .sel       (sel),
        .rd        (rd),
        .wr        (wr),
        .ld_ir     (ld_ir),
        .ld_ac     (ld_ac),
        .ld_pc     (ld_pc),
        .inc_pc    (inc_pc),
        .data_e    (data_e),
        .halt      (halt),
        .phase     (phase),
        .instr_cnt (instr_cnt)
`ifdef RISC_SEQ_SINGLE_STEP_EN
        ,
        .step      (step)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected strobe vector {sel,rd,wr,ld_ir,ld_ac,ld_pc,inc_pc,data_e,halt}
    // derived from the per-phase strobe table.
    function automatic logic [8:0] exp_strobes(int ph, bit h, logic [2:0] op, logic z);
        bit alu;
        logic [8:0] v;
        alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        if (h) return 9'b0_0000_0001;
        v[8] = (ph < 4);
        v[7] = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        v[6] = (ph == 7) && (op == 3'd6);
        v[5] = (ph == 2) || (ph == 3);
        v[4] = (ph == 7) && alu;
        v[3] = (ph >= 6) && (op == 3'd7);
        v[2] = ((ph == 4) && (op != 3'd0)) || ((ph == 6) && (op == 3'd1) && z);
        v[1] = (ph >= 6) && (op == 3'd6);
        v[0] = (ph == 4) && (op == 3'd0);
        return v;
    endfunction

    task automatic check_outputs();
        chk("strobes", {23'd0, sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt},
            {23'd0, exp_strobes(m_phase, m_halted, opcode, zero)});
        chk("phase", {29'd0, phase}, m_phase);
        chk("instr_cnt", {16'd0, instr_cnt}, m_cnt[IC_W-1:0]);
    endtask

    // One clock: apply inputs, check outputs mid-cycle, step model at posedge.
    task automatic cycle(input logic [2:0] op, input logic z, input logic e, input logic st);
        opcode = op;
        zero   = z;
        ena    = e;
`ifdef RISC_SEQ_SINGLE_STEP_EN
        step   = st;
`else
        step   = st;
`endif
        #2;
        check_outputs();
        $display("cyc %0d ph=%0d op=%0d ena=%0d z=%0d halt=%0d cnt=%0d",
                 cyc, phase, op, e, z, halt, instr_cnt);
        @(posedge clk);
        cyc++;
        if (!m_halted) begin
            if (!e) begin
                m_phase = 0;
            end else if (m_phase == 4 && op == 3'd0) begin
                m_halted = 1;
                m_phase = 0;
`ifdef RISC_SEQ_SINGLE_STEP_EN
            end else if (m_phase == 0 && !st) begin
                m_phase = 0;
`endif
            end else if (m_phase == 7) begin
                m_phase = 0;
                m_cnt = (m_cnt + 1) % (1 << IC_W);
            end else begin
                m_phase++;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [2:0] op, input logic z);
        for (int i = 0; i < 8; i++) cycle(op, z, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_phase = 0; m_halted = 0; m_cnt = 0;
        opcode = 3'd0;
        #1;
        chk("reset_strobes", {23'd0, sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt},
            32'h100);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        @(negedge clk);
        do_reset();
        chk("reset_phase", {29'd0, phase}, 0);
        chk("reset_cnt", {16'd0, instr_cnt}, 0);

        // ADD, SKZ taken, SKZ not taken, STO, JMP
        run_instr(3'd2, 1'b0);
        chk("add_retired", {16'd0, instr_cnt}, 1);
        run_instr(3'd1, 1'b1);
        run_instr(3'd1, 1'b0);
        run_instr(3'd6, 1'b0);
        run_instr(3'd7, 1'b1);
        chk("five_retired", {16'd0, instr_cnt}, 5);

        // HLT as the third instruction after reset
        do_reset();
        run_instr(3'd2, 1'b0);
        run_instr(3'd3, 1'b1);
        for (int i = 0; i < 5; i++) cycle(3'd0, 1'b0, 1'b1, 1'b1);
        chk("halted_flag", {31'd0, halt}, 1);
        for (int i = 0; i < 20; i++) cycle(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'b1);
        chk("halted_cnt", {16'd0, instr_cnt}, 2);
        chk("halted_phase", {29'd0, phase}, 0);
        do_reset();
        chk("unhalt", {31'd0, halt}, 0);

        // Abort in phase 5, and abort coincident with HLT in phase 4
        run_instr(3'd4, 1'b0);
        for (int i = 0; i < 5; i++) cycle(3'd5, 1'b0, 1'b1, 1'b1);
        chk("at_phase5", {29'd0, phase}, 5);
        cycle(3'd5, 1'b0, 1'b0, 1'b1);
        chk("abort_phase", {29'd0, phase}, 0);
        chk("abort_cnt", {16'd0, instr_cnt}, 1);
        cycle(3'd5, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(3'd0, 1'b0, 1'b1, 1'b1);
        cycle(3'd0, 1'b0, 1'b0, 1'b1);
        chk("abort_beats_hlt", {31'd0, halt}, 0);

        // Asynchronous reset in the middle of phase 3
        for (int i = 0; i < 3; i++) cycle(3'd2, 1'b0, 1'b1, 1'b1);
        chk("at_phase3", {29'd0, phase}, 3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_phase", {29'd0, phase}, 0);
        chk("async_cnt", {16'd0, instr_cnt}, 0);
        m_phase = 0; m_halted = 0; m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;

`ifdef RISC_SEQ_SINGLE_STEP_EN
        for (int i = 0; i < 10; i++) cycle(3'd2, 1'b0, 1'b1, 1'b0);
        chk("step_hold", {29'd0, phase}, 0);
        cycle(3'd2, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) cycle(3'd2, 1'b0, 1'b1, 1'b0);
        chk("step_one_instr", {16'd0, instr_cnt}, 1);
        chk("step_parked", {29'd0, phase}, 0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 15));
            cycle((r == 0) ? 3'd0 : 3'($urandom_range(1, 7)), 1'($urandom),
                  ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0));
            if (m_halted && ($urandom_range(0, 3) == 0)) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
